timekeeper_core: RTL

//  Parametrised time-of-day counter: holds HH:MM:SS, advances once per CLK_HZ clocks and formats the hour as 12h or 24h.

---
 rtl/timekeeper_core.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/timekeeper_core.sv
// timekeeper_core: HH:MM:SS time-of-day counter with prescaler, per-field edits,
// parallel load, run/hold, 12h/24h hour formatting and tick/midnight pulses.
module timekeeper_core #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned PRE_W      = 27,
  parameter int unsigned EDIT_CARRY = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       mode24,
  input  logic       up,
  input  logic       down,
  input  logic       clear,
  input  logic [2:0] cursor_pos,
  input  logic       load,
  input  logic [5:0] load_hour,
  input  logic [5:0] load_minute,
  input  logic [5:0] load_second,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       pm,
  output logic       sec_tick,
  output logic       midnight,
  output logic       load_err
);

  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CLK_HZ - 1);
  localparam logic [5:0]       MS_MAX    = 6'd59;
  localparam logic [5:0]       HOUR_MAX  = 6'd23;
  localparam logic             CARRY_EN  = (EDIT_CARRY != 0);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic             pend_q, pend_d;
  logic             sec_tick_q, sec_tick_d;
  logic             midnight_q, midnight_d;
  logic             load_err_q, load_err_d;

  logic tick_c, load_ok_c, edit_ok_c, cursor_onehot_c;

  // Next value of a field moving one step up or down with wrap.
  function automatic logic [5:0] step_val(input logic [5:0] v, input logic [5:0] vmax,
                                          input logic inc);
    if (inc) step_val = (v == vmax) ? 6'd0 : v + 6'd1;
    else     step_val = (v == 6'd0) ? vmax : v - 6'd1;
  endfunction

  // True when the step wraps the field (and would carry/borrow).
  function automatic logic step_wrap(input logic [5:0] v, input logic [5:0] vmax,
                                     input logic inc);
    step_wrap = inc ? (v == vmax) : (v == 6'd0);
  endfunction

  // Qualifiers for tick, load and edit.
  always_comb begin
    tick_c          = run && (pre_q == PRE_MAX);
    load_ok_c       = (load_hour <= HOUR_MAX) && (load_minute <= MS_MAX) &&
                      (load_second <= MS_MAX);
    cursor_onehot_c = (cursor_pos == 3'b001) || (cursor_pos == 3'b010) ||
                      (cursor_pos == 3'b100);
    edit_ok_c       = (up ^ down) && cursor_onehot_c;
  end

  // Next-state: clear > load > edit > tick, with one deferred tick behind an edit.
  always_comb begin
    pre_d      = pre_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    pend_d     = pend_q;
    sec_tick_d = 1'b0;
    midnight_d = 1'b0;
    load_err_d = 1'b0;

    if (run) pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);

    if (clear) begin
      sec_d  = 6'd0;
      min_d  = 6'd0;
      hour_d = 6'd0;
      pre_d  = '0;
      pend_d = 1'b0;
    end else if (load) begin
      if (load_ok_c) begin
        sec_d  = load_second;
        min_d  = load_minute;
        hour_d = load_hour;
        pre_d  = '0;
        pend_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (edit_ok_c) begin
      if (cursor_pos[0]) begin
        sec_d = step_val(sec_q, MS_MAX, up);
        if (CARRY_EN && step_wrap(sec_q, MS_MAX, up)) begin
          min_d = step_val(min_q, MS_MAX, up);
          if (step_wrap(min_q, MS_MAX, up)) hour_d = step_val(hour_q, HOUR_MAX, up);
        end
      end
      if (cursor_pos[1]) begin
        min_d = step_val(min_q, MS_MAX, up);
        if (CARRY_EN && step_wrap(min_q, MS_MAX, up)) hour_d = step_val(hour_q, HOUR_MAX, up);
      end
      if (cursor_pos[2]) hour_d = step_val(hour_q, HOUR_MAX, up);
      if (tick_c) pend_d = 1'b1;
    end else if (tick_c || pend_q) begin
      sec_d = step_val(sec_q, MS_MAX, 1'b1);
      if (sec_q == MS_MAX) begin
        min_d = step_val(min_q, MS_MAX, 1'b1);
        if (min_q == MS_MAX) hour_d = step_val(hour_q, HOUR_MAX, 1'b1);
      end
      sec_tick_d = 1'b1;
      midnight_d = (sec_q == MS_MAX) && (min_q == MS_MAX) && (hour_q == HOUR_MAX);
      // A fresh tick arriving while one is pending stays pending.
      pend_d     = tick_c && pend_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q      <= '0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 6'd0;
      pend_q     <= 1'b0;
      sec_tick_q <= 1'b0;
      midnight_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      pend_q     <= pend_d;
      sec_tick_q <= sec_tick_d;
      midnight_q <= midnight_d;
      load_err_q <= load_err_d;
    end
  end

  // Output formatting; hour is combinational from the true 0-23 hour.
  always_comb begin
    minute   = min_q;
    second   = sec_q;
    sec_tick = sec_tick_q;
    midnight = midnight_q;
    load_err = load_err_q;
    pm       = (hour_q >= 6'd12);
    if (mode24)              hour = hour_q;
    else if (hour_q == 6'd0) hour = 6'd12;
    else if (hour_q > 6'd12) hour = hour_q - 6'd12;
    else                     hour = hour_q;
  end

endmodule
